prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side checker for the shift-register (LFSR) pattern generator in the counters set.
//  Self-synchronises to a serial 1-bit pattern stream, declares lock and counts bit errors.
//  Sits at the far end of a serial test link, for loop-back and bit-error-rate checks on counter and pattern generators.
// PARAMETERS
//  WIDTH        4   length of the local prediction shift register (>=2)
//  TAP_A        3   first feedback tap index into the shift register (< WIDTH)
//  TAP_B        2   second feedback tap index (< WIDTH, != TAP_A)
//  LOCK_COUNT   8   consecutive correct predictions needed to declare lock
//  UNLOCK_ERRS  4   consecutive mismatches while locked that force a resync
//  ERR_W        16  width of the error counter
// PORTS
//  clk         in   1      single clock; all state updates on its rising edge
//  rst         in   1      reset: synchronous, active-high
//  din_valid   in   1      din is sampled only when high; low = hold all state
//  din         in   1      received serial pattern bit
//  clear_errs  in   1      synchronous clear of err_count
//  locked      out  1      high while state == LOCKED
//  err_pulse   out  1      one-cycle pulse per mismatch detected in LOCKED
//  err_count   out  ERR_W  saturating count of mismatches seen in LOCKED
// BEHAVIOUR
//  Reset (rst=1 at a rising clk edge):
//   - state = SEED; shift reg s = 0; seed/good/bad counters = 0.
//   - locked = 0, err_pulse = 0, err_count = 0.
//   - rst has priority over every other input, including mid-lock.
//  Prediction: p = s[TAP_A] ^ s[TAP_B]; shift is s <= {s[WIDTH-2:0], bit}.
//  All transitions happen only on cycles with din_valid=1. When din_valid=0:
//   - s, state and all counters hold.
//   - err_pulse is driven 0.
//  States:
//   - SEED:   shift in din; after WIDTH valid bits -> VERIFY.
//             If the loaded s == 0, reload: stay in SEED and restart the seed count.
//   - VERIFY: compare din with p; shift in din.
//             Match: good++; reaching LOCK_COUNT -> LOCKED.
//             Mismatch: clear s and good; -> SEED.
//   - LOCKED: shift in p (not din), so received errors do not propagate into s.
//             Match: clear bad.
//             Mismatch: err_pulse=1 next cycle, err_count++ (saturating), bad++.
//             bad reaching UNLOCK_ERRS -> SEED, clearing s, good and bad (err_count keeps its value).
//  Outputs are registered:
//   - locked rises in the cycle after the LOCK_COUNT-th match.
//   - err_pulse appears in the cycle after the erroneous bit; latency 1.
//  err_count:
//   - saturates at all-ones; never wraps.
//   - clear_errs together with a new error in the same cycle -> err_count = 1.
//   - clear_errs alone -> 0.
//  Lock latency from reset with a clean stream: WIDTH + LOCK_COUNT valid bits, +1 cycle.
// STRUCTURE
//  Package prbs_pkg:
//   - state typedef {SEED, VERIFY, LOCKED}, 2 bits.
//   - default WIDTH/TAP_A/TAP_B constants shared with the generator side.
//  Sub-module prbs_predictor:
//   - WIDTH-bit shift register with load-select (din or p), clear and enable.
//   - outputs p combinationally.
//  Top level holds the FSM, good/bad/seed counters and the error counter.
// TESTING
//  Golden model: x^4+x^3+1 generator (b[n] = b[n-4] ^ b[n-3]), seed 4'b0001, period 15.
//  1) Clean stream from reset: locked=0 through bit 11; locked=1 the cycle after bit 12.
//     err_count stays 0 over 100 bits.
//  2) Locked, invert bit 30 only: err_pulse high exactly 1 cycle; err_count=1; locked stays 1.
//  3) Locked, invert bits 40-43 (4 consecutive): err_count=4, then locked=0.
//     Clean re-lock follows 12 valid bits later.
//  4) All-zero din for 40 bits: locked stays 0; err_count stays 0; FSM never leaves SEED.
//  5) Scenario 1 with din_valid low for 3 cycles after every valid bit:
//     same valid-bit indices for locked/err events; no err_pulse during gaps.
//  6) ERR_W=4, 20 isolated single-bit errors spaced 5 bits apart: err_count saturates at 15.
//     clear_errs coincident with an error -> 1.
//     rst mid-LOCKED -> locked=0, err_count=0 the next cycle.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types and default pattern constants for the serial pattern checker.
// The default taps match the generator side's x^4+x^3+1 polynomial.
package prbs_pkg;

  typedef enum logic [1:0] {
    StSeed   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefTapA  = 3;
  localparam int unsigned DefTapB  = 2;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prbs_predictor.sv
// Local prediction shift register. The next expected bit is the XOR of two
// taps; the register loads either the received bit or its own prediction.
module prbs_predictor
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TAP_A = DefTapA,
  parameter int unsigned TAP_B = DefTapB
) (
  input  logic clk,
  input  logic rst,
  input  logic en,         // shift one bit in
  input  logic clr,        // clear to zero, wins over en
  input  logic sel_pred,   // 1: shift in own prediction, 0: shift in din
  input  logic din,
  output logic p,          // predicted next bit
  output logic load_zero   // value that en would load is all zeros
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] load_val;
  logic             bit_in;

  assign p         = s_q[TAP_A] ^ s_q[TAP_B];
  assign bit_in    = sel_pred ? p : din;
  assign load_val  = {s_q[WIDTH-2:0], bit_in};
  assign load_zero = (load_val == '0);

  // Next register value: clear, shift, or hold.
  always_comb begin
    s_d = s_q;
    if (clr) begin
      s_d = '0;
    end else if (en) begin
      s_d = load_val;
    end
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side checker for the LFSR pattern generator. Seeds a local copy of
// the generator from the incoming stream, verifies it, declares lock, and then
// counts mismatches against its own free-running prediction.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned TAP_A       = DefTapA,
  parameter int unsigned TAP_B       = DefTapB,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned SeedW = cnt_width(WIDTH);
  localparam int unsigned GoodW = cnt_width(LOCK_COUNT);
  localparam int unsigned BadW  = cnt_width(UNLOCK_ERRS);

  localparam logic [SeedW-1:0] SeedLast = SeedW'(WIDTH - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_COUNT - 1);
  localparam logic [BadW-1:0]  BadLast  = BadW'(UNLOCK_ERRS - 1);

  state_e           state_q, state_d;
  logic [SeedW-1:0] seed_q, seed_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [BadW-1:0]  bad_q, bad_d;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic pred_en;
  logic pred_clr;
  logic pred_sel;
  logic p;
  logic load_zero;
  logic match;
  logic lock_err;

  prbs_predictor #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_predictor (
    .clk       (clk),
    .rst       (rst),
    .en        (pred_en),
    .clr       (pred_clr),
    .sel_pred  (pred_sel),
    .din       (din),
    .p         (p),
    .load_zero (load_zero)
  );

  assign match = (din == p);

  // FSM next state, counter updates and predictor control; idle when din_valid is low.
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    good_d   = good_q;
    bad_d    = bad_q;
    pred_en  = 1'b0;
    pred_clr = 1'b0;
    pred_sel = 1'b0;
    lock_err = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StSeed: begin
          pred_en = 1'b1;
          if (seed_q == SeedLast) begin
            seed_d = '0;
            // An all-zero seed would predict zeros forever; keep reloading.
            if (!load_zero) begin
              state_d = StVerify;
            end
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end

        StVerify: begin
          if (match) begin
            pred_en = 1'b1;
            if (good_q == GoodLast) begin
              good_d  = '0;
              state_d = StLocked;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            pred_clr = 1'b1;
            good_d   = '0;
            state_d  = StSeed;
          end
        end

        StLocked: begin
          // Free-run on the prediction so a bad received bit cannot corrupt s.
          pred_en  = 1'b1;
          pred_sel = 1'b1;
          if (match) begin
            bad_d = '0;
          end else begin
            lock_err = 1'b1;
            if (bad_q == BadLast) begin
              pred_clr = 1'b1;
              good_d   = '0;
              bad_d    = '0;
              state_d  = StSeed;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end

        default: begin
          pred_clr = 1'b1;
          seed_d   = '0;
          good_d   = '0;
          bad_d    = '0;
          state_d  = StSeed;
        end
      endcase
    end
  end

  // Saturating error counter; a clear coincident with an error leaves one count.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_errs) begin
      err_count_d = lock_err ? ERR_W'(1) : '0;
    end else if (lock_err && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSeed;
      seed_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= (state_d == StLocked);
      err_pulse_q <= lock_err;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. Two instances (16-bit and 4-bit error
// counters) see identical stimulus; expectations are queued per driven cycle.
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        din_valid;
  logic        din;
  logic        clear_errs;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;

  prbs_checker #(
    .ERR_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clear_errs (clear_errs),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  prbs_checker #(
    .ERR_W (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clear_errs (clear_errs),
    .locked     (locked4),
    .err_pulse  (err_pulse4),
    .err_count  (err_count4)
  );

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Golden x^4+x^3+1 stream, seed 0001: b[n] = b[n-4] ^ b[n-3].
  logic stream [0:255];
  int   idx;
  // Behavioural expectations: lock after 12 clean valid bits, unlock after 4
  // consecutive mismatches while locked, error count tracked unsaturated.
  int   since_sync;
  int   bad_run;
  int   true_cnt;
  logic exp_lock;

  task automatic compare(input string tag);
    exp_t e;
    n_assert++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: got empty queue, want an entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_assert++;
      assert (locked === e.lk) else begin
        n_fail++;
        $error("FAIL %s locked: got %b want %b", tag, locked, e.lk);
      end
      n_assert++;
      assert (err_pulse === e.ep) else begin
        n_fail++;
        $error("FAIL %s err_pulse: got %b want %b", tag, err_pulse, e.ep);
      end
      n_assert++;
      assert (err_count === e.c16) else begin
        n_fail++;
        $error("FAIL %s err_count: got %0d want %0d", tag, err_count, e.c16);
      end
      n_assert++;
      assert (locked4 === e.lk) else begin
        n_fail++;
        $error("FAIL %s locked4: got %b want %b", tag, locked4, e.lk);
      end
      n_assert++;
      assert (err_pulse4 === e.ep) else begin
        n_fail++;
        $error("FAIL %s err_pulse4: got %b want %b", tag, err_pulse4, e.ep);
      end
      n_assert++;
      assert (err_count4 === e.c4) else begin
        n_fail++;
        $error("FAIL %s err_count4: got %0d want %0d", tag, err_count4, e.c4);
      end
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic clr, input logic ep,
                       input string tag);
    exp_t e;
    din_valid  = v;
    din        = b;
    clear_errs = clr;
    e.lk  = exp_lock;
    e.ep  = ep;
    e.c16 = (true_cnt > 65535) ? 16'hffff : 16'(true_cnt);
    e.c4  = (true_cnt > 15) ? 4'hf : 4'(true_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // One valid bit from the golden stream, optionally inverted (only while locked).
  task automatic vbit(input logic flip, input logic clr, input string tag);
    logic b;
    logic err;
    b   = stream[idx] ^ flip;
    idx = idx + 1;
    err = flip && exp_lock;
    if (exp_lock) begin
      if (err) begin
        true_cnt++;
        bad_run++;
      end else begin
        bad_run = 0;
      end
      if (bad_run == 4) begin
        exp_lock   = 1'b0;
        since_sync = 0;
        bad_run    = 0;
      end
    end else begin
      since_sync++;
      if (since_sync == 12) exp_lock = 1'b1;
    end
    if (clr) true_cnt = err ? 1 : 0;
    drive(1'b1, b, clr, err, tag);
  endtask

  task automatic gap(input string tag);
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input logic v, input string tag);
    rst        = 1'b1;
    exp_lock   = 1'b0;
    true_cnt   = 0;
    idx        = 0;
    since_sync = 0;
    bad_run    = 0;
    drive(v, 1'b1, 1'b0, 1'b0, tag);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) stream[i] = (i == 3);
    for (int i = 4; i < 256; i++) stream[i] = stream[i-4] ^ stream[i-3];

    // 1) Clean stream: lock after bit 12, no errors over 100 bits.
    do_reset(1'b0, "reset");
    for (int k = 1; k <= 100; k++) vbit(1'b0, 1'b0, "s1_clean");

    // 2) Single inverted bit while locked.
    do_reset(1'b0, "s2_reset");
    for (int k = 1; k <= 35; k++) vbit(k == 30, 1'b0, "s2_single");

    // 3) Four consecutive errors force resync, then clean relock.
    do_reset(1'b0, "s3_reset");
    for (int k = 1; k <= 70; k++) vbit((k >= 40) && (k <= 43), 1'b0, "s3_burst");

    // 4) All-zero input never locks; then a clean stream locks in 12 bits.
    do_reset(1'b0, "s4_reset");
    for (int k = 1; k <= 40; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, "s4_zeros");
    idx = 0;
    since_sync = 0;
    for (int k = 1; k <= 14; k++) vbit(1'b0, 1'b0, "s4_relock");

    // 5) Clean stream with three idle cycles after every valid bit.
    do_reset(1'b0, "s5_reset");
    for (int k = 1; k <= 20; k++) begin
      vbit(1'b0, 1'b0, "s5_valid");
      for (int g = 0; g < 3; g++) gap("s5_gap");
    end

    // 6) Saturation of the narrow counter, clear behaviour, reset while locked.
    do_reset(1'b0, "s6_reset");
    for (int k = 1; k <= 12; k++) vbit(1'b0, 1'b0, "s6_lock");
    for (int e = 0; e < 20; e++) begin
      vbit(1'b1, 1'b0, "s6_err");
      for (int c = 0; c < 4; c++) vbit(1'b0, 1'b0, "s6_clean");
    end
    vbit(1'b1, 1'b1, "s6_clr_err");
    for (int c = 0; c < 4; c++) vbit(1'b0, 1'b0, "s6_clean2");
    vbit(1'b0, 1'b1, "s6_clr_only");
    vbit(1'b1, 1'b0, "s6_err_after_clr");
    vbit(1'b0, 1'b0, "s6_clean3");
    vbit(1'b0, 1'b0, "s6_clean4");
    do_reset(1'b1, "s6_rst_locked");
    vbit(1'b0, 1'b0, "s6_post_rst");

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
